// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_prog
// Description : Programmable clock divider. Even divisors give a 50% duty
//               clock from the rising-edge phase flop. Odd divisors OR in a
//               falling-edge copy of that flop, which stretches the high phase
//               by half a cycle. Divisor changes are deferred to a period
//               boundary, so a running period is never cut short or lengthened.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             div_ack,
  output logic             div_err,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [WIDTH-1:0] C_DEFAULT_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] C_DEFAULT_CNT = WIDTH'(DEFAULT_DIV - 1);
  localparam logic [WIDTH-1:0] C_ONE         = WIDTH'(1);
  localparam logic [WIDTH-1:0] C_MIN_DIV     = WIDTH'(2);

  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             p_q, p_d;
  logic             pn_q, pn_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;

  logic             at_end;
  logic             apply_pend;
  logic [WIDTH-1:0] div_eff;

  // Period boundary detection and the divisor that governs this edge
  always_comb begin
    at_end     = (cnt_q == (div_q - C_ONE));
    apply_pend = pend_vld_q && (!en || at_end);
    div_eff    = apply_pend ? pend_q : div_q;
  end

  // Next-state: counter/phase, pending divisor handoff, load validation
  always_comb begin
    div_d      = div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    cnt_d      = cnt_q;
    p_d        = p_q;
    tick_d     = 1'b0;
    ack_d      = 1'b0;
    err_d      = 1'b0;

    if (apply_pend) begin
      div_d      = pend_q;
      pend_vld_d = 1'b0;
      ack_d      = 1'b1;
    end

    if (en) begin
      cnt_d  = at_end ? '0 : (cnt_q + C_ONE);
      p_d    = (cnt_d < (div_eff >> 1));
      tick_d = at_end;
    end else begin
      // Parked on the last count so the first enabled edge starts a period
      cnt_d = div_eff - C_ONE;
      p_d   = 1'b0;
    end

    // A load on a boundary edge is evaluated after the handoff, so it stays
    // pending for the next boundary instead of being applied now
    if (div_load) begin
      if (div_in >= C_MIN_DIV) begin
        pend_d     = div_in;
        pend_vld_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Falling-edge copy of the phase flop
  always_comb begin
    pn_d = p_q;
  end

  // Rising-edge state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q      <= C_DEFAULT_DIV;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      cnt_q      <= C_DEFAULT_CNT;
      p_q        <= 1'b0;
      tick_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      cnt_q      <= cnt_d;
      p_q        <= p_d;
      tick_q     <= tick_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  // Half-cycle delayed phase used only for odd divisors
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pn_q <= 1'b0;
    end else begin
      pn_q <= pn_d;
    end
  end

  // Output clock: overlap of p and pn keeps the odd-divisor output glitch-free
  always_comb begin
    clk_out = div_q[0] ? (p_q | pn_q) : p_q;
  end

  assign tick    = tick_q;
  assign div_ack = ack_q;
  assign div_err = err_q;

endmodule
`default_nettype wire
